// File: rtl/beat_scheduler_pkg.sv
// Shared definitions for the song sequencer: default widths, FSM encoding
// and the ROM entry field markers.
package beat_scheduler_pkg;

   localparam int DEF_SONG_BITS  = 2;
   localparam int DEF_IDX_BITS   = 5;
   localparam int DEF_NOTE_WIDTH = 6;
   localparam int DEF_DUR_WIDTH  = 6;

   // ROM entry layout: {note, duration}, note in the upper bits.
   localparam logic [DEF_NOTE_WIDTH-1:0] NOTE_REST = '0;
   localparam logic [DEF_DUR_WIDTH-1:0]  DUR_END   = '0;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_FETCH    = 3'd1;
   localparam state_t ST_WAIT_ROM = 3'd2;
   localparam state_t ST_ISSUE    = 3'd3;
   localparam state_t ST_HOLD     = 3'd4;
   localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/beat_scheduler_countdown.sv
// Loadable down-counter measuring how many beats the current entry still owns.
module beat_countdown #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = value;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/beat_scheduler.sv
// Walks a song ROM entry by entry, hands notes to the player with a req/ack
// handshake and holds each one for its duration in beats.
module beat_scheduler
   import beat_scheduler_pkg::*;
#(
   parameter int SONG_BITS  = DEF_SONG_BITS,
   parameter int IDX_BITS   = DEF_IDX_BITS,
   parameter int NOTE_WIDTH = DEF_NOTE_WIDTH,
   parameter int DUR_WIDTH  = DEF_DUR_WIDTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            play,
   input  logic [SONG_BITS-1:0]            song,
   input  logic                            beat,
   output logic [SONG_BITS+IDX_BITS-1:0]   rom_addr,
   input  logic [NOTE_WIDTH+DUR_WIDTH-1:0] rom_data,
   output logic [NOTE_WIDTH-1:0]           note,
   output logic                            new_note,
   input  logic                            note_ack,
   output logic                            song_done,
   output logic                            playing
);

   state_t                          state_q, state_d;
   logic [SONG_BITS-1:0]            song_q, song_d;
   logic [IDX_BITS-1:0]             idx_q, idx_d, idx_inc;
   logic [SONG_BITS+IDX_BITS-1:0]   addr_q, addr_d;
   logic [NOTE_WIDTH-1:0]           note_q, note_d;
   logic                            new_note_q, new_note_d;
   logic                            cnt_load, cnt_dec, cnt_zero, abort;
   logic [NOTE_WIDTH-1:0]           rom_note;
   logic [DUR_WIDTH-1:0]            rom_dur;

   assign rom_note = rom_data[NOTE_WIDTH+DUR_WIDTH-1 -: NOTE_WIDTH];
   assign rom_dur  = rom_data[DUR_WIDTH-1:0];
   assign idx_inc  = idx_q + 1'b1;

   // A song change while active abandons playback; IDLE then picks up the new song.
   assign abort   = (state_q != ST_IDLE) && (state_q != ST_DONE) && (song != song_q);
   assign cnt_dec = (state_q == ST_HOLD) && beat && play;

   beat_countdown #(.W(DUR_WIDTH)) u_countdown (
      .clk   (clk),
      .rst_n (reset),
      .load  (cnt_load),
      .value (rom_dur),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   // rom_addr is loaded on entry to FETCH so the ROM sees the address during FETCH.
   always_comb begin
      state_d    = state_q;
      song_d     = song_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      note_d     = note_q;
      new_note_d = new_note_q;
      cnt_load   = 1'b0;
      if (abort) begin
         state_d    = ST_IDLE;
         new_note_d = 1'b0;
         note_d     = '0;
         idx_d      = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (play) begin
               song_d  = song;
               idx_d   = '0;
               addr_d  = {song, {IDX_BITS{1'b0}}};
               state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_WAIT_ROM;
            ST_WAIT_ROM: begin
               if (rom_dur == DUR_WIDTH'(DUR_END)) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_load = 1'b1;
                  if (rom_note == NOTE_WIDTH'(NOTE_REST)) begin
                     state_d = ST_HOLD;
                  end else begin
                     note_d     = rom_note;
                     new_note_d = 1'b1;
                     state_d    = ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: if (note_ack) begin
               new_note_d = 1'b0;
               state_d    = ST_HOLD;
            end
            ST_HOLD: if (cnt_zero) begin
               if (&idx_q) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_inc;
                  addr_d  = {song_q, idx_inc};
                  state_d = ST_FETCH;
               end
            end
            ST_DONE: begin
               idx_d   = '0;
               note_d  = '0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         song_q     <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         note_q     <= '0;
         new_note_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         song_q     <= song_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         note_q     <= note_d;
         new_note_q <= new_note_d;
      end
   end

   assign rom_addr  = addr_q;
   assign note      = note_q;
   assign new_note  = new_note_q;
   assign song_done = (state_q == ST_DONE);
   assign playing   = (state_q != ST_IDLE);

endmodule

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
- Sequences song playback from the 32 Hz beat pulse produced by the beat generator.
- Steps through a song ROM of {note, duration} entries and hands each note to the note player with a request/acknowledge handshake.
- Holds each note for its duration in beats, then fetches the next entry.
- Provides play/pause, song select, end-of-song detection and a song-done pulse; sits between the beat generator, the song ROM and the note player.

Parameters:
- SONG_BITS, 2, song select width (4 songs).
- IDX_BITS, 5, entry index width (32 entries per song).
- NOTE_WIDTH, 6, note code width; code 0 = rest.
- DUR_WIDTH, 6, duration width in beats; code 0 = end-of-song marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- play  in  1  level; 1 = run, 0 = pause.
- song  in  SONG_BITS  song select.
- beat  in  1  one-cycle pulse from the beat generator.
- rom_addr  out  SONG_BITS+IDX_BITS  {song_latched, idx}; registered.
- rom_data  in  NOTE_WIDTH+DUR_WIDTH  {note, duration}; valid one cycle after rom_addr changes.
- note  out  NOTE_WIDTH  current note code; registered.
- new_note  out  1  request to note player; held until note_ack.
- note_ack  in  1  note player accepted the note.
- song_done  out  1  one-cycle pulse at end of song.
- playing  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, idx = 0, song_latched = 0.
  - rom_addr, note, new_note, song_done and playing all 0 immediately, independent of clk.
- States: IDLE, FETCH, WAIT_ROM, ISSUE, HOLD, DONE.
- IDLE: when play = 1 at a clk edge, latch song, set idx = 0, go to FETCH.
- FETCH:
  - rom_addr = {song_latched, idx}.
  - Next state is WAIT_ROM unconditionally.
- WAIT_ROM: sample rom_data.
  - duration == 0 -> DONE.
  - note == 0 (rest) -> load countdown with duration, go to HOLD; no request issued.
  - otherwise -> note <= note field, load countdown with duration, go to ISSUE.
- ISSUE:
  - new_note = 1, held while note_ack = 0.
  - On the cycle note_ack = 1, new_note drops the following cycle and state moves to HOLD.
  - Beats arriving in ISSUE are ignored.
- Latency: new_note rises on the 3rd clk edge after play is sampled high in IDLE (IDLE->FETCH->WAIT_ROM->ISSUE).
- HOLD: countdown decrements on each cycle with beat = 1 and play = 1.
  - Countdown reaches 0 and idx != all-ones -> idx + 1, go to FETCH.
  - Countdown reaches 0 and idx == all-ones -> go to DONE (no wrap within a song).
  - A note of duration N therefore lasts exactly N counted beats.
  - A beat in the same cycle HOLD is entered is not counted.
- Pause: play = 0 freezes the HOLD countdown and blocks IDLE exit.
  - FETCH, WAIT_ROM and ISSUE run to completion while paused.
  - note keeps its value during pause.
- DONE:
  - song_done = 1 for exactly one cycle.
  - idx = 0, note = 0, next state IDLE.
  - With play still 1, IDLE immediately restarts the song.
- Song change: if song != song_latched in any state other than IDLE or DONE, abort.
  - Next state is IDLE, new_note = 0, note = 0, idx = 0.
  - No song_done pulse.
  - Abort has priority over all other transitions, including an outstanding note_ack.
- Simultaneous events:
  - beat and play falling in the same cycle -> beat not counted.
  - note_ack asserted outside ISSUE -> ignored.
- rom_addr holds its last value outside FETCH.

Decomposition:
- Shared package: state enum, NOTE_REST = 0, DUR_END = 0, entry field positions (note = upper NOTE_WIDTH bits, duration = lower DUR_WIDTH bits).
- Sub-module beat_countdown: loadable DUR_WIDTH down-counter.
  - Inputs: load, value, dec enable (beat & play).
  - Output: zero.
  - Asynchronous active-low reset.

Test Plan:
- Entry 0 = {note 5, dur 3}, play = 1 from reset release -> new_note rises 3 cycles after play is sampled; hold ack low 4 cycles -> new_note held; ack -> next fetch (rom_addr 1) only after the 3rd beat.
- Entry 1 = {note 0, dur 2} (rest) -> new_note never asserts; rom_addr advances to 2 after 2 beats.
- Entry 2 = {any, dur 0} -> song_done one-cycle pulse, playing falls, note = 0, then the song restarts at rom_addr {song, 0} with play held.
- Pause mid-HOLD with dur 4: 2 beats, play low for 5 beats, play high, 2 beats -> advance happens only after the 4th counted beat.
- Change song 0->2 during ISSUE -> new_note drops the next cycle, no song_done, restart fetch at rom_addr {2, 0}.
- Song with all 32 entries of dur 1 -> after idx 31 completes, song_done pulses, no wrap to idx 0 without passing through IDLE; reset asserted mid-HOLD -> all outputs 0 immediately.
